divisor_seq: RTL

Sequential unsigned restoring divider, the inverse of the team's pipelined multiplier. It takes a 2·TAM-bit dividend (the width of a multiplier product) and a TAM-bit divisor, and computes one quotient bit per clock. It reports the quotient and remainder through a start/busy/done handshake. It sits next to the multiplier in the arithmetic datapath and is used for product checks and scaling.

---
 rtl/divisor_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/divisor_seq.sv
// Sequential unsigned restoring divider: 2*TAM-bit dividend / TAM-bit divisor, one quotient bit per clock.
// Optional DIVISOR_ZERO_DET_EN: short-circuits D==0 to a flagged all-ones result without iterating.
module divisor_seq #(
    parameter int TAM = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*TAM-1:0] N,
    input  logic [TAM-1:0]   D,
    output logic [2*TAM-1:0] Q,
    output logic [TAM-1:0]   R,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    localparam int CNT_W = $clog2(2*TAM+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2*TAM);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [2*TAM-1:0] dvd;     // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [TAM-1:0]   dsr;
    logic [TAM-1:0]   rem;
    logic [TAM:0]     rem_sh;  // the extra remainder bit only exists in this compare operand
    logic [TAM-1:0]   rem_nxt;
    logic             ge, accept, last_it, zero_hit, fin;
    logic [2*TAM-1:0] q_fin;
    logic [TAM-1:0]   r_fin;

    assign accept  = (state == IDLE) && start;
    assign last_it = (cnt == LAST);
    assign rem_sh  = {rem, dvd[2*TAM-1]};
    assign ge      = (rem_sh >= {1'b0, dsr});
    assign rem_nxt = ge ? TAM'(rem_sh - {1'b0, dsr}) : rem_sh[TAM-1:0];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

`ifdef DIVISOR_ZERO_DET_EN
    logic zflag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zflag <= 1'b0;
            div0  <= 1'b0;
        end else begin
            if (accept)
                zflag <= (D == '0);
            if (fin)
                div0 <= zflag;
        end
    end

    assign zero_hit = zflag;
    assign q_fin    = zflag ? '1 : dvd;
    assign r_fin    = zflag ? dvd[TAM-1:0] : rem;
`else
    assign zero_hit = 1'b0;
    assign q_fin    = dvd;
    assign r_fin    = rem;
    assign div0     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (last_it || zero_hit) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            Q     <= '0;
            R     <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == RUN && !last_it)
                cnt <= cnt + CNT_W'(1);
            if (fin) begin
                Q <= q_fin;
                R <= r_fin;
            end
        end
    end

    // Working datapath registers carry no reset; they are always loaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd <= N;
            dsr <= D;
            rem <= '0;
        end else if (state == RUN && !last_it) begin
            dvd <= {dvd[2*TAM-2:0], ge};
            rem <= rem_nxt;
        end
    end
endmodule
